// File: rtl/marquee_pkg.sv
// marquee_pkg: state encoding, mode constants and step counter width for marquee_ctrl
package marquee_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  typedef enum logic [1:0] {M_ROL = 2'b00, M_ROR = 2'b01, M_FILL = 2'b10, M_BOUNCE = 2'b11} mode_t;
  localparam int STEP_W = 4;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: shift-tick prescaler; tick fires one cycle ahead of the terminal count so a registered strobe lands on it
module tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || cnt == W'(TICK_DIV - 1)) ? '0 : cnt + W'(1);
  assign tick = !clr && cnt == W'(TICK_DIV - 2);
endmodule

// File: rtl/marquee_ctrl.sv
// marquee_ctrl: shift-register sequencer (rotate/fill/bounce); bounce direction toggling needs MARQUEE_BOUNCE_EN, else mode 11 acts as rotate-left
module marquee_ctrl
  import marquee_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int STEPS    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [7:0]        pattern,
  input  logic              fill_bit,
  output logic              load,
  output logic              shift_en,
  output logic              SL,
  output logic              sin,
  output logic              cycle,
  output logic [7:0]        pin,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step_cnt
);
  state_t state, nxt;
  mode_t mode_q, cap_mode, cur_mode;
  logic tick, clr, shift, fill_end, active;
`ifdef MARQUEE_BOUNCE_EN
  assign cap_mode = mode_t'(mode);
`else
  assign cap_mode = mode == M_BOUNCE ? M_ROL : mode_t'(mode);
`endif
  assign clr = state != RUN;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .clr(clr), .tick(tick));
  assign fill_end = mode_q == M_FILL && step_cnt == STEP_W'(STEPS);
  always_comb begin
    nxt = state == IDLE ? (start ? LOAD : IDLE)
        : state == LOAD ? (stop ? DONE : RUN)
        : state == RUN  ? ((stop || fill_end) ? DONE : RUN)
        : IDLE;
    shift = state == RUN && nxt == RUN && tick;
    active = nxt == LOAD || nxt == RUN;
    cur_mode = state == IDLE ? cap_mode : mode_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      mode_q   <= M_ROL;
      load     <= 1'b0;
      shift_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      SL       <= 1'b1;
      sin      <= 1'b0;
      cycle    <= 1'b1;
      pin      <= '0;
      step_cnt <= '0;
    end else begin
      state    <= nxt;
      load     <= nxt == LOAD;
      shift_en <= shift;
      busy     <= active;
      done     <= nxt == DONE;
      sin      <= active && cur_mode == M_FILL && fill_bit;
      if (state == IDLE && start) begin
        mode_q <= cap_mode;
        pin    <= pattern;
        SL     <= cap_mode != M_ROR;
        cycle  <= cap_mode != M_FILL;
      end
      if (state == LOAD && nxt == RUN) step_cnt <= '0;
      else if (shift) step_cnt <= (mode_q != M_FILL && step_cnt == STEP_W'(STEPS - 1)) ? '0 : step_cnt + 1'b1;
`ifdef MARQUEE_BOUNCE_EN
      // flip after the wrapping shift so that shift itself still uses the old direction
      if (mode_q == M_BOUNCE && shift_en && step_cnt == '0) SL <= ~SL;
`endif
    end
endmodule

// File: doc/marquee_ctrl.md
MARQUEE_CTRL -- requirements
Module: marquee_ctrl

Interface
- REQ-001 Parameter TICK_DIV, default 100_000_000: clk cycles per shift tick (1 s at 100 MHz); legal range >= 2.
- REQ-002 Parameter STEPS, default 8: shift ticks per pass; legal range 2..15.
- REQ-003 The interface SHALL contain one clock, clk; reset is asynchronous and active-low, named rst_n.
- REQ-004 clk  in  1  system clock; all logic on rising edge.
- REQ-005 rst_n  in  1  asynchronous active-low reset.
- REQ-006 start  in  1  single-cycle synchronous request to begin a sequence.
- REQ-007 stop  in  1  single-cycle synchronous abort request.
- REQ-008 mode  in  2  00 rotate-left, 01 rotate-right, 10 fill-left, 11 bounce.
- REQ-009 pattern  in  8  value to preload into the shift register.
- REQ-010 fill_bit  in  1  serial input bit used in fill-left mode.
- REQ-011 load  out  1  parallel-load strobe to the shift register.
- REQ-012 shift_en  out  1  one-cycle shift strobe, asserted once per tick.
- REQ-013 SL  out  1  shift direction: 1 = left, 0 = right.
- REQ-014 sin  out  1  serial input to the shift register.
- REQ-015 cycle  out  1  1 = rotate, 0 = serial fill.
- REQ-016 pin  out  8  captured pattern, held stable while busy.
- REQ-017 busy  out  1  high in LOAD and RUN.
- REQ-018 done  out  1  one-cycle pulse on sequence end.
- REQ-019 step_cnt  out  4  ticks completed in the current pass.

Function
- REQ-020 The FSM SHALL have four states: IDLE, LOAD, RUN, DONE.
- REQ-021 IDLE: start=1 SHALL capture pattern and mode and go to LOAD; start in any other state SHALL be ignored.
- REQ-022 LOAD lasts exactly one cycle with load=1, then goes to RUN; the prescaler and step_cnt are cleared on entry to RUN.
- REQ-023 RUN: the prescaler counts 0..TICK_DIV-1 and wraps; at the terminal count, shift_en=1 for that cycle and step_cnt increments, so the first shift occurs TICK_DIV cycles after entering RUN.
- REQ-024 Modes 00 and 01 SHALL drive cycle=1, with SL=1 or SL=0 respectively; the sequence runs continuously and step_cnt wraps STEPS-1 -> 0.
- REQ-025 Mode 10 SHALL drive cycle=0, SL=1, sin=fill_bit; on the tick that completes STEPS shifts, the next state is DONE.
- REQ-026 Mode 11 SHALL drive cycle=1, start with SL=1, and toggle SL on every step_cnt wrap; the sequence runs until stop.
- REQ-027 stop in LOAD or RUN SHALL go to DONE on the next edge; a tick coinciding with stop SHALL NOT produce shift_en; stop in IDLE or DONE is ignored.
- REQ-028 DONE lasts one cycle with done=1, then goes to IDLE; step_cnt holds its last value until the next LOAD.
- REQ-029 Outputs SHALL be registered; load, shift_en and done are never high in the same cycle.

Reset
- REQ-030 rst_n=0 SHALL immediately force IDLE, with the prescaler=0, step_cnt=0, pin=0, SL=1, sin=0, cycle=1, and load, shift_en, busy and done all 0; this includes reset mid-sequence.

Configuration
- REQ-031 With MARQUEE_BOUNCE_EN defined, mode 11 SHALL behave per REQ-026; without it, mode 11 SHALL behave exactly as mode 00 and the SL-toggle logic is absent.

Structure
- REQ-032 Package marquee_pkg SHALL hold the state encoding (IDLE, LOAD, RUN, DONE), the mode constants, and the step_cnt width.
- REQ-033 The prescaler SHALL be a sub-module tick_gen (inputs clk, rst_n, clr; output tick), parameterised by TICK_DIV.

Verification (TICK_DIV=4, STEPS=8)
- REQ-034 Reset -> start with mode=00, pattern=8'h81 -> load high at cycle 1; shift_en at cycles 5, 9, 13...; SL=1, cycle=1, pin=8'h81.
- REQ-035 mode=10, fill_bit=1 -> exactly 8 shift_en pulses, then done pulse one cycle after the 8th, then busy=0.
- REQ-036 mode=11 with MARQUEE_BOUNCE_EN -> SL=1 for the first 8 ticks, SL=0 for the next 8, then SL=1 again; without the macro, SL stays 1.
- REQ-037 stop asserted in the same cycle as a tick -> no shift_en, done on the next cycle; a start during RUN is ignored.
- REQ-038 rst_n low mid-RUN -> all outputs at their reset values asynchronously; a later start is accepted normally.
